axi_rd_lane_unpack: RTL and testbench

- Read-side counterpart of the write-strobe/lane-mask generator.
- Takes a read request (address, size, length, burst type) and then consumes beats of the 64-bit read-data bus.
- For each beat it computes the active byte lanes, right-justifies the addressed bytes and zero-fills the rest.
- Sits between the AXI-like read-data channel and narrow consumers (CPU load unit, debug port).

---
 rtl/axi_rd_lane_unpack.sv | 149 ++++++++++++++
 tb/tb_axi_rd_lane_unpack.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_lane_unpack.sv
// Read-data lane unpacker: selects the addressed bytes of each 64-bit read beat,
// right-justifies them, zero-fills the rest and tags each beat with last/error status.
module axi_rd_lane_unpack #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ar_valid,
   output logic              ar_ready,
   input  logic [ADDR_W-1:0] ar_addr,
   input  logic [1:0]        ar_size,
   input  logic [LEN_W-1:0]  ar_len,
   input  logic [1:0]        ar_burst,
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [63:0]       r_data,
   input  logic              r_last,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [63:0]       o_data,
   output logic [7:0]        o_lane,
   output logic              o_last,
   output logic              o_err
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t             state_reg, state_next;
   logic [ADDR_W-1:0]  addr_reg, addr_next;
   logic [1:0]         size_reg, size_next;
   logic [LEN_W-1:0]   len_reg, len_next;
   logic [LEN_W-1:0]   count_reg, count_next;
   logic               fixed_reg, fixed_next;
   logic               o_valid_reg, o_valid_next;
   logic [63:0]        o_data_reg, o_data_next;
   logic [7:0]         o_lane_reg, o_lane_next;
   logic               o_last_reg, o_last_next;
   logic               o_err_reg, o_err_next;

   logic               accept;
   logic [2:0]         lo;
   logic [7:0]         lane_base;
   logic [63:0]        data_mask;
   logic [ADDR_W-1:0]  step;
   logic [ADDR_W-1:0]  aligned;
   logic               beat_last;

   // Lane offset of the current beat, rounded down to the beat size.
   always_comb begin
      lo        = (addr_reg[2:0] >> size_reg) << size_reg;
      step      = ADDR_W'(4'd1 << size_reg);
      aligned   = addr_reg & ~(step - ADDR_W'(1));
      beat_last = (count_reg == len_reg);
      case (size_reg)
         2'd0:    begin lane_base = 8'h01; data_mask = 64'h0000_0000_0000_00FF; end
         2'd1:    begin lane_base = 8'h03; data_mask = 64'h0000_0000_0000_FFFF; end
         2'd2:    begin lane_base = 8'h0F; data_mask = 64'h0000_0000_FFFF_FFFF; end
         default: begin lane_base = 8'hFF; data_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
      endcase
   end

   always_comb begin
      state_next   = state_reg;
      addr_next    = addr_reg;
      size_next    = size_reg;
      len_next     = len_reg;
      count_next   = count_reg;
      fixed_next   = fixed_reg;
      o_valid_next = o_valid_reg;
      o_data_next  = o_data_reg;
      o_lane_next  = o_lane_reg;
      o_last_next  = o_last_reg;
      o_err_next   = o_err_reg;

      ar_ready = (state_reg == IDLE);
      r_ready  = (state_reg == BUSY) && (!o_valid_reg || o_ready);
      accept   = r_valid && r_ready;

      case (state_reg)
         IDLE: begin
            if (ar_valid) begin
               addr_next  = ar_addr;
               size_next  = ar_size;
               len_next   = ar_len;
               fixed_next = (ar_burst == 2'b00);
               count_next = '0;
               state_next = BUSY;
            end
         end
         default: begin
            if (accept) begin
               count_next = count_reg + LEN_W'(1);
               if (!fixed_reg)
                  addr_next = aligned + step;
               // Own count ends the burst regardless of what r_last says.
               if (beat_last)
                  state_next = IDLE;
            end
         end
      endcase

      // Output stage: a new beat overwrites a draining one with no bubble.
      if (accept) begin
         o_valid_next = 1'b1;
         o_data_next  = (r_data >> {lo, 3'b000}) & data_mask;
         o_lane_next  = lane_base << lo;
         o_last_next  = beat_last;
         o_err_next   = (r_last != beat_last);
      end else if (o_ready && o_valid_reg) begin
         o_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         size_reg    <= '0;
         len_reg     <= '0;
         count_reg   <= '0;
         fixed_reg   <= 1'b0;
         o_valid_reg <= 1'b0;
         o_data_reg  <= '0;
         o_lane_reg  <= '0;
         o_last_reg  <= 1'b0;
         o_err_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         size_reg    <= size_next;
         len_reg     <= len_next;
         count_reg   <= count_next;
         fixed_reg   <= fixed_next;
         o_valid_reg <= o_valid_next;
         o_data_reg  <= o_data_next;
         o_lane_reg  <= o_lane_next;
         o_last_reg  <= o_last_next;
         o_err_reg   <= o_err_next;
      end
   end

   assign o_valid = o_valid_reg;
   assign o_data  = o_data_reg;
   assign o_lane  = o_lane_reg;
   assign o_last  = o_last_reg;
   assign o_err   = o_err_reg;

endmodule

// File: tb/tb_axi_rd_lane_unpack.sv
// Directed bench for axi_rd_lane_unpack: inputs change and outputs are sampled on the falling edge.
module tb_axi_rd_lane_unpack;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ar_valid;
   logic        ar_ready;
   logic [31:0] ar_addr;
   logic [1:0]  ar_size;
   logic [7:0]  ar_len;
   logic [1:0]  ar_burst;
   logic        r_valid;
   logic        r_ready;
   logic [63:0] r_data;
   logic        r_last;
   logic        o_valid;
   logic        o_ready;
   logic [63:0] o_data;
   logic [7:0]  o_lane;
   logic        o_last;
   logic        o_err;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   axi_rd_lane_unpack #(.ADDR_W(32), .LEN_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
      .ar_size(ar_size), .ar_len(ar_len), .ar_burst(ar_burst),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_lane(o_lane),
      .o_last(o_last), .o_err(o_err)
   );

   // Issue one request starting at a falling edge; returns at the falling edge after acceptance.
   task automatic do_req(input logic [31:0] a, input logic [1:0] s,
                         input logic [7:0] l, input logic [1:0] b);
      int n = 0;
      ar_addr = a; ar_size = s; ar_len = l; ar_burst = b; ar_valid = 1'b1;
      while (!ar_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (ar_ready !== 1'b1) begin
         $display("FAIL req_accept ar_ready=%b required 1 after %0d cycles", ar_ready, n);
         failed++;
      end
      @(negedge clk);
      ar_valid = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      tests++;
      if (o_valid !== 1'b0 || o_data !== 64'h0 || o_lane !== 8'h0 || o_last !== 1'b0 ||
          o_err !== 1'b0 || ar_ready !== 1'b1 || r_ready !== 1'b0) begin
         $display("FAIL reset_state o_valid=%b o_data=%h o_lane=%h o_last=%b o_err=%b ar_ready=%b r_ready=%b required 0 0 0 0 0 1 0",
                  o_valid, o_data, o_lane, o_last, o_err, ar_ready, r_ready);
         failed++;
      end
      rst_n = 1'b1;
      @(negedge clk);
      // Beats presented while idle must be ignored.
      r_valid = 1'b1; r_data = 64'h1234_5678_9ABC_DEF0; r_last = 1'b1;
      tests++;
      if (r_ready !== 1'b0) begin
         $display("FAIL idle_r_ready r_ready=%b required 0", r_ready);
         failed++;
      end
      @(negedge clk);
      r_valid = 1'b0; r_last = 1'b0;
      tests++;
      if (o_valid !== 1'b0) begin
         $display("FAIL idle_ignore o_valid=%b required 0", o_valid);
         failed++;
      end
   endtask

   task automatic test_single;
      o_ready = 1'b1;
      do_req(32'h5, 2'd0, 8'd0, 2'd1);
      r_valid = 1'b1; r_data = 64'h8877_6655_4433_2211; r_last = 1'b1;
      tests++;
      if (r_ready !== 1'b1 || o_valid !== 1'b0) begin
         $display("FAIL single_pre r_ready=%b o_valid=%b required 1 0", r_ready, o_valid);
         failed++;
      end
      @(negedge clk);
      r_valid = 1'b0; r_last = 1'b0;
      tests++;
      if (o_valid !== 1'b1 || o_data !== 64'h66 || o_lane !== 8'h20 || o_last !== 1'b1 ||
          o_err !== 1'b0 || ar_ready !== 1'b1) begin
         $display("FAIL single_beat o_valid=%b o_data=%h o_lane=%h o_last=%b o_err=%b ar_ready=%b required 1 66 20 1 0 1",
                  o_valid, o_data, o_lane, o_last, o_err, ar_ready);
         failed++;
      end
      @(negedge clk);
      tests++;
      if (o_valid !== 1'b0) begin
         $display("FAIL single_drain o_valid=%b required 0", o_valid);
         failed++;
      end
   endtask

   task automatic test_incr;
      logic [63:0] d  [3] = '{64'h1122_3344_5566_7788, 64'hAABB_CCDD_EEFF_0011, 64'h0102_0304_0506_0708};
      logic [63:0] ed [3] = '{64'h1122_3344, 64'hEEFF_0011, 64'h0102_0304};
      logic [7:0]  el [3] = '{8'hF0, 8'h0F, 8'hF0};
      logic        exp_last;
      o_ready = 1'b1;
      do_req(32'h6, 2'd2, 8'd2, 2'd1);
      r_valid = 1'b1; r_data = d[0]; r_last = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         exp_last = (k == 2);
         tests++;
         if (o_valid !== 1'b1 || o_data !== ed[k] || o_lane !== el[k] || o_last !== exp_last || o_err !== 1'b0) begin
            $display("FAIL incr_beat%0d o_valid=%b o_data=%h o_lane=%h o_last=%b o_err=%b required 1 %h %h %b 0",
                     k, o_valid, o_data, o_lane, o_last, o_err, ed[k], el[k], exp_last);
            failed++;
         end
         if (k < 2) begin
            r_data = d[k+1]; r_last = (k + 1 == 2);
         end else begin
            r_valid = 1'b0; r_last = 1'b0;
         end
      end
      tests++;
      if (ar_ready !== 1'b1) begin
         $display("FAIL incr_idle ar_ready=%b required 1", ar_ready);
         failed++;
      end
      @(negedge clk);
   endtask

   task automatic test_fixed;
      logic [63:0] d  [4] = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888,
                              64'h9999_0000_AAAA_BBBB, 64'hDEAD_BEEF_CAFE_F00D};
      logic [63:0] ed [4] = '{64'h3333, 64'h7777, 64'hAAAA, 64'hCAFE};
      logic        exp_last;
      o_ready = 1'b1;
      do_req(32'h3, 2'd1, 8'd3, 2'd0);
      r_valid = 1'b1; r_data = d[0]; r_last = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         exp_last = (k == 3);
         tests++;
         if (o_valid !== 1'b1 || o_data !== ed[k] || o_lane !== 8'h0C || o_last !== exp_last || o_err !== 1'b0) begin
            $display("FAIL fixed_beat%0d o_valid=%b o_data=%h o_lane=%h o_last=%b o_err=%b required 1 %h 0c %b 0",
                     k, o_valid, o_data, o_lane, o_last, o_err, ed[k], exp_last);
            failed++;
         end
         if (k < 3) begin
            r_data = d[k+1]; r_last = (k + 1 == 3);
         end else begin
            r_valid = 1'b0; r_last = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   // Size-3 INCR burst from an unaligned address while the consumer stalls for 5 cycles.
   task automatic test_backpressure;
      logic [63:0] d [4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                             64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_3C3C_C3C3};
      logic        exp_last;
      o_ready = 1'b0;
      do_req(32'h5, 2'd3, 8'd3, 2'd1);
      r_valid = 1'b1; r_data = d[0]; r_last = 1'b0;
      @(negedge clk);
      r_data = d[1];
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         tests++;
         if (r_ready !== 1'b0 || o_valid !== 1'b1 || o_data !== d[0] || o_lane !== 8'hFF ||
             o_last !== 1'b0 || o_err !== 1'b0) begin
            $display("FAIL bp_hold%0d r_ready=%b o_valid=%b o_data=%h o_lane=%h o_last=%b o_err=%b required 0 1 %h ff 0 0",
                     i, r_ready, o_valid, o_data, o_lane, o_last, o_err, d[0]);
            failed++;
         end
      end
      o_ready = 1'b1;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         exp_last = (k == 3);
         tests++;
         if (o_valid !== 1'b1 || o_data !== d[k] || o_lane !== 8'hFF || o_last !== exp_last || o_err !== 1'b0) begin
            $display("FAIL bp_beat%0d o_valid=%b o_data=%h o_lane=%h o_last=%b o_err=%b required 1 %h ff %b 0",
                     k, o_valid, o_data, o_lane, o_last, o_err, d[k], exp_last);
            failed++;
         end
         if (k < 3) begin
            r_data = d[k+1]; r_last = (k + 1 == 3);
         end else begin
            r_valid = 1'b0; r_last = 1'b0;
         end
      end
      @(negedge clk);
      tests++;
      if (o_valid !== 1'b0 || ar_ready !== 1'b1) begin
         $display("FAIL bp_end o_valid=%b ar_ready=%b required 0 1", o_valid, ar_ready);
         failed++;
      end
   endtask

   task automatic test_early_last;
      logic        rl [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic        ee [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [7:0]  el [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
      logic [63:0] exp_data;
      logic        exp_last;
      o_ready = 1'b1;
      do_req(32'h0, 2'd0, 8'd3, 2'd1);
      r_valid = 1'b1; r_data = 64'h0807_0605_0403_0201; r_last = rl[0];
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         exp_data = 64'(k + 1);
         exp_last = (k == 3);
         tests++;
         if (o_valid !== 1'b1 || o_data !== exp_data || o_lane !== el[k] || o_last !== exp_last || o_err !== ee[k]) begin
            $display("FAIL early_beat%0d o_valid=%b o_data=%h o_lane=%h o_last=%b o_err=%b required 1 %h %h %b %b",
                     k, o_valid, o_data, o_lane, o_last, o_err, exp_data, el[k], exp_last, ee[k]);
            failed++;
         end
         if (k < 3) r_last = rl[k+1];
         else begin
            r_valid = 1'b0; r_last = 1'b0;
         end
      end
      @(negedge clk);
   endtask

   // A pending beat held by backpressure must not block the next request.
   task automatic test_back_to_back;
      o_ready = 1'b0;
      do_req(32'h0, 2'd0, 8'd0, 2'd1);
      r_valid = 1'b1; r_data = 64'h0000_0000_0000_CDAB; r_last = 1'b1;
      @(negedge clk);
      r_valid = 1'b0;
      tests++;
      if (o_valid !== 1'b1 || ar_ready !== 1'b1 || o_data !== 64'hAB) begin
         $display("FAIL b2b_held o_valid=%b ar_ready=%b o_data=%h required 1 1 ab", o_valid, ar_ready, o_data);
         failed++;
      end
      do_req(32'h1, 2'd0, 8'd0, 2'd1);
      tests++;
      if (r_ready !== 1'b0 || o_data !== 64'hAB || o_lane !== 8'h01) begin
         $display("FAIL b2b_stall r_ready=%b o_data=%h o_lane=%h required 0 ab 01", r_ready, o_data, o_lane);
         failed++;
      end
      o_ready = 1'b1;
      r_valid = 1'b1;
      @(negedge clk);
      r_valid = 1'b0; r_last = 1'b0;
      tests++;
      if (o_valid !== 1'b1 || o_data !== 64'hCD || o_lane !== 8'h02 || o_last !== 1'b1 || o_err !== 1'b0) begin
         $display("FAIL b2b_second o_valid=%b o_data=%h o_lane=%h o_last=%b o_err=%b required 1 cd 02 1 0",
                  o_valid, o_data, o_lane, o_last, o_err);
         failed++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      o_ready = 1'b0;
      do_req(32'h0, 2'd3, 8'd7, 2'd1);
      r_valid = 1'b1; r_data = 64'h1111_1111_1111_1111; r_last = 1'b0;
      @(negedge clk);
      tests++;
      if (o_valid !== 1'b1) begin
         $display("FAIL rstmid_beat1 o_valid=%b required 1", o_valid);
         failed++;
      end
      rst_n = 1'b0; r_valid = 1'b0;
      #1;
      tests++;
      if (o_valid !== 1'b0 || ar_ready !== 1'b1 || r_ready !== 1'b0 || o_data !== 64'h0) begin
         $display("FAIL rstmid_async o_valid=%b ar_ready=%b r_ready=%b o_data=%h required 0 1 0 0",
                  o_valid, ar_ready, r_ready, o_data);
         failed++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (ar_ready !== 1'b1 || o_valid !== 1'b0) begin
         $display("FAIL rstmid_release ar_ready=%b o_valid=%b required 1 0", ar_ready, o_valid);
         failed++;
      end
      o_ready = 1'b1;
      do_req(32'h0, 2'd3, 8'd0, 2'd1);
      r_valid = 1'b1; r_data = 64'hCAFE_BABE_1234_5678; r_last = 1'b1;
      @(negedge clk);
      r_valid = 1'b0; r_last = 1'b0;
      tests++;
      if (o_valid !== 1'b1 || o_lane !== 8'hFF || o_data !== 64'hCAFE_BABE_1234_5678 ||
          o_last !== 1'b1 || o_err !== 1'b0) begin
         $display("FAIL rstmid_fresh o_valid=%b o_lane=%h o_data=%h o_last=%b o_err=%b required 1 ff cafebabe12345678 1 0",
                  o_valid, o_lane, o_data, o_last, o_err);
         failed++;
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; ar_valid = 1'b0; ar_addr = '0; ar_size = '0; ar_len = '0; ar_burst = '0;
      r_valid = 1'b0; r_data = '0; r_last = 1'b0; o_ready = 1'b0;
      repeat (2) @(negedge clk);
      test_reset;
      test_single;
      test_incr;
      test_fixed;
      test_backpressure;
      test_early_last;
      test_back_to_back;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
